// File: rtl/cdc_handshake_tx.sv
// Source side of a four-phase req/ack crossing: holds an accepted word on xfer_data
// while xfer_req is high and waits for the resynchronized far-domain acknowledge.
module cdc_handshake_tx #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             xfer_req,
  output logic [WIDTH-1:0] xfer_data,
  input  logic             xfer_ack,
  output logic             busy
);

  // state   | meaning
  // IDLE    | no handshake; accept when ack_s is low
  // REQ     | xfer_req high, waiting for ack_s to rise
  // RELEASE | xfer_req low, waiting for ack_s to fall
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   req_q, req_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack_s;
  logic                   accept;

  // The chain keeps tracking xfer_ack through reset, so an ack left high by an
  // interrupted handshake still holds off in_ready; with ack low it flushes to 0.
  always_ff @(posedge clk) begin
    ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], xfer_ack};
  end

  assign ack_s    = ack_sync_q[SYNC_STAGES-1];
  assign in_ready = (state_q == IDLE) && !ack_s;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = REQ;
          data_d  = in_data;
        end
      end
      REQ: begin
        if (ack_s) state_d = RELEASE;
      end
      RELEASE: begin
        if (!ack_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    req_d = (state_d == REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
    end
  end

  assign xfer_req  = req_q;
  assign xfer_data = data_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx: reset, single transfer timing, data hold,
// stream with a far-side responder, reset mid-REQ and spurious ack.
module tb_cdc_handshake_tx;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        xfer_req;
  logic [31:0] xfer_data;
  logic        xfer_ack;
  logic        busy;

  int total;
  int bad;

  cdc_handshake_tx #(.WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .xfer_req (xfer_req),
    .xfer_data(xfer_data),
    .xfer_ack (xfer_ack),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one rising edge, then return to the falling edge where we sample and drive
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; xfer_ack = 1'b0;
    @(negedge clk);
    repeat (3) tick();
    rst = 1'b0;
    total++;
    if (xfer_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", xfer_req); end
    total++;
    if (xfer_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", xfer_data); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", in_ready); end
    tick();
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_idle ready=%b busy=%b want ready=1 busy=0", in_ready, busy);
    end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_data = 32'hDEADBEEF;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL single_ready_pre got=%b want=1", in_ready); end
    tick();
    in_valid = 1'b0; in_data = 32'h0;
    total++;
    if (xfer_req !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
      bad++; $display("FAIL single_accept req=%b busy=%b ready=%b want 1 1 0", xfer_req, busy, in_ready);
    end
    tick();
    xfer_ack = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      total++;
      if (xfer_req !== (e < 3)) begin
        bad++; $display("FAIL single_req_fall edge=%0d got=%b want=%b", e, xfer_req, (e < 3));
      end
      total++;
      if (xfer_data !== 32'hDEADBEEF) begin
        bad++; $display("FAIL single_data edge=%0d got=%h want=deadbeef", e, xfer_data);
      end
    end
    tick();
    xfer_ack = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      total++;
      if (in_ready !== (e == 3)) begin
        bad++; $display("FAIL single_ready_rise edge=%0d got=%b want=%b", e, in_ready, (e == 3));
      end
      total++;
      if (xfer_req !== 1'b0 || xfer_data !== 32'hDEADBEEF) begin
        bad++; $display("FAIL single_release edge=%0d req=%b data=%h want 0 deadbeef", e, xfer_req, xfer_data);
      end
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b want=0", busy); end
  endtask

  task automatic test_data_hold();
    in_valid = 1'b1; in_data = 32'hA5A50001;
    tick();
    // ack follows req immediately at each falling edge; in_ready expected back at i=6
    for (int i = 0; i <= 6; i++) begin
      in_data = 32'h1000 + i;
      if (xfer_req && !xfer_ack) xfer_ack = 1'b1;
      else if (!xfer_req && xfer_ack) xfer_ack = 1'b0;
      total++;
      if (xfer_data !== 32'hA5A50001) begin
        bad++; $display("FAIL hold_data i=%0d got=%h want=a5a50001", i, xfer_data);
      end
      total++;
      if (in_ready !== (i == 6)) begin
        bad++; $display("FAIL hold_ready i=%0d got=%b want=%b", i, in_ready, (i == 6));
      end
      tick();
    end
    in_valid = 1'b0;
    total++;
    if (xfer_data !== 32'h1006 || xfer_req !== 1'b1) begin
      bad++; $display("FAIL hold_second_accept data=%h req=%b want 1006 1", xfer_data, xfer_req);
    end
    tick();
    xfer_ack = 1'b1;
    for (int n = 0; n < 20 && xfer_req; n++) tick();
    xfer_ack = 1'b0;
    for (int n = 0; n < 20 && !in_ready; n++) tick();
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL hold_drain ready=%b want=1", in_ready); end
  endtask

  task automatic test_stream();
    logic [31:0] cap [4];
    int ncap;
    int n;
    ncap = 0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = k + 1;
      n = 0;
      while (!in_ready && n < 30) begin tick(); n++; end
      total++;
      if (!in_ready) begin bad++; $display("FAIL stream_ready_timeout word=%0d got=0 want=1", k); end
      tick();
      in_valid = 1'b0; in_data = 32'hFFFFFFFF;
      n = 0;
      while (!xfer_req && n < 30) begin tick(); n++; end
      total++;
      if (!xfer_req) begin bad++; $display("FAIL stream_req_timeout word=%0d got=0 want=1", k); end
      if (ncap < 4) cap[ncap] = xfer_data;
      ncap++;
      xfer_ack = 1'b1;
      n = 0;
      while (xfer_req && n < 30) begin tick(); n++; end
      xfer_ack = 1'b0;
    end
    n = 0;
    while (!in_ready && n < 30) begin tick(); n++; end
    total++;
    if (ncap !== 4) begin bad++; $display("FAIL stream_count got=%0d want=4", ncap); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (cap[k] !== k + 1) begin bad++; $display("FAIL stream_word k=%0d got=%h want=%h", k, cap[k], k + 1); end
    end
  endtask

  task automatic test_reset_mid_req();
    int n;
    in_valid = 1'b1; in_data = 32'h55;
    tick();
    in_valid = 1'b0;
    xfer_ack = 1'b1;
    tick();
    tick();
    total++;
    if (xfer_req !== 1'b1) begin bad++; $display("FAIL midrst_pre_req got=%b want=1", xfer_req); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b1; in_data = 32'h66;
    total++;
    if (xfer_req !== 1'b0 || xfer_data !== 32'h0 || busy !== 1'b0) begin
      bad++; $display("FAIL midrst_clear req=%b data=%h busy=%b want 0 0 0", xfer_req, xfer_data, busy);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (in_ready !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL midrst_blocked i=%0d ready=%b busy=%b want 0 0", i, in_ready, busy);
      end
      tick();
    end
    xfer_ack = 1'b0;
    in_valid = 1'b0;
    tick();
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready_e1 got=%b want=0", in_ready); end
    tick();
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready_e2 got=%b want=1", in_ready); end
    in_valid = 1'b1; in_data = 32'h77;
    tick();
    in_valid = 1'b0;
    total++;
    if (xfer_req !== 1'b1 || xfer_data !== 32'h77) begin
      bad++; $display("FAIL midrst_reaccept req=%b data=%h want 1 77", xfer_req, xfer_data);
    end
    xfer_ack = 1'b1;
    n = 0;
    while (xfer_req && n < 20) begin tick(); n++; end
    xfer_ack = 1'b0;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_drain ready=%b want=1", in_ready); end
  endtask

  task automatic test_spurious_ack();
    logic exp_ready [5];
    exp_ready = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    in_valid = 1'b0;
    xfer_ack = 1'b1;
    for (int e = 0; e < 5; e++) begin
      tick();
      if (e == 1) xfer_ack = 1'b0;
      total++;
      if (in_ready !== exp_ready[e] || xfer_req !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL spurious edge=%0d ready=%b req=%b busy=%b want ready=%b req=0 busy=0",
                 e + 1, in_ready, xfer_req, busy, exp_ready[e]);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_data_hold();
    test_stream();
    test_reset_mid_req();
    test_spurious_ack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
